// File: rtl/red_pitaya_pwm_mc.sv
// Multi-channel dithered PWM generator with one shared period counter and double-buffered config.
// Optional center-aligned pulses are enabled by defining RP_PWM_CENTER_EN, which adds the align port.
module red_pitaya_pwm_mc #(
    parameter  int CHN = 4,
    parameter  int DW  = 8,
    parameter  int DTH = 16,
    parameter  int PER = 156,
    localparam int CCW = DW + DTH,
    localparam int IW  = (DTH > 1) ? $clog2(DTH) : 1,
    localparam int CW  = (PER > 1) ? $clog2(PER) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [CHN*CCW-1:0] cfg,
    input  logic               cfg_we,
`ifdef RP_PWM_CENTER_EN
    input  logic [CHN-1:0]     align,
`endif
    output logic               cfg_pend,
    output logic [CHN-1:0]     pwm_o,
    output logic               pwm_s,
    output logic [IW-1:0]      dth_idx
);

    // Two spare bits so duty+dither and lo+thr never wrap.
    localparam int TW = DW + 2;

    logic [CW-1:0]            cnt;
    logic [CHN*CCW-1:0]       pending;
    logic [CHN*CCW-1:0]       active;
    logic                     boundary;
    logic [TW-1:0]            cnt_x;
    logic [CHN-1:0][TW-1:0]   thr;
    logic [CHN-1:0]           pwm_nxt;
`ifdef RP_PWM_CENTER_EN
    logic [CHN-1:0]           align_act;
    logic [CHN-1:0][TW-1:0]   lo;
`endif

    assign boundary = en && (cnt == CW'(PER - 1));
    assign cnt_x    = TW'(cnt);

    always_comb begin
        logic [TW-1:0] sum;
        sum     = '0;
        thr     = '0;
        pwm_nxt = '0;
`ifdef RP_PWM_CENTER_EN
        lo      = '0;
`endif
        for (int n = 0; n < CHN; n++) begin
            sum    = TW'(active[n*CCW+DTH +: DW]) + TW'(active[n*CCW + int'(dth_idx)]);
            thr[n] = (sum > TW'(PER)) ? TW'(PER) : sum;
`ifdef RP_PWM_CENTER_EN
            lo[n]  = (TW'(PER) - thr[n]) >> 1;
            pwm_nxt[n] = align_act[n] ? ((cnt_x >= lo[n]) && (cnt_x < lo[n] + thr[n]))
                                      : (cnt_x < thr[n]);
`else
            pwm_nxt[n] = cnt_x < thr[n];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            dth_idx   <= '0;
            pending   <= '0;
            active    <= '0;
            cfg_pend  <= 1'b0;
            pwm_o     <= '0;
            pwm_s     <= 1'b0;
`ifdef RP_PWM_CENTER_EN
            align_act <= '0;
`endif
        end else begin
            if (cfg_we) begin
                pending  <= cfg;
                cfg_pend <= 1'b1;
            end else if (boundary) begin
                cfg_pend <= 1'b0;
            end
            // A write on the boundary cycle still promotes the old pending word.
            if (boundary) begin
                active    <= pending;
`ifdef RP_PWM_CENTER_EN
                align_act <= align;
`endif
            end
            if (en) begin
                cnt   <= boundary ? '0 : cnt + CW'(1);
                pwm_o <= pwm_nxt;
                pwm_s <= boundary;
                if (boundary)
                    dth_idx <= (dth_idx == IW'(DTH - 1)) ? '0 : dth_idx + IW'(1);
            end else begin
                cnt     <= '0;
                dth_idx <= '0;
                pwm_o   <= '0;
                pwm_s   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_pwm_mc.sv
// Directed bench for red_pitaya_pwm_mc: idle, integer duty, dither, update timing, en/reset.
// Center-aligned checks run only when RP_PWM_CENTER_EN is defined.
module tb_red_pitaya_pwm_mc;

    localparam int CHN = 4;
    localparam int DW  = 8;
    localparam int DTH = 16;
    localparam int PER = 156;
    localparam int CCW = DW + DTH;

    logic               clk = 1'b0;
    logic               rstn;
    logic               en;
    logic [CHN*CCW-1:0] cfg;
    logic               cfg_we;
    logic               cfg_pend;
    logic [CHN-1:0]     pwm_o;
    logic               pwm_s;
    logic [3:0]         dth_idx;
`ifdef RP_PWM_CENTER_EN
    logic [CHN-1:0]     align;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int tb_idx = 0;
    int hi[CHN];
    int first_hi[CHN];
    int last_hi[CHN];

    red_pitaya_pwm_mc #(.CHN(CHN), .DW(DW), .DTH(DTH), .PER(PER)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .cfg      (cfg),
        .cfg_we   (cfg_we),
`ifdef RP_PWM_CENTER_EN
        .align    (align),
`endif
        .cfg_pend (cfg_pend),
        .pwm_o    (pwm_o),
        .pwm_s    (pwm_s),
        .dth_idx  (dth_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and keep the expected dither index in step.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rstn || !en) tb_idx = 0;
        else if (pwm_s)   tb_idx = (tb_idx + 1) % DTH;
    endtask

    function automatic logic [CCW-1:0] w(input int duty, input logic [DTH-1:0] d);
        return {duty[DW-1:0], d};
    endfunction

    task automatic write_cfg(input logic [CHN*CCW-1:0] v);
        cfg    = v;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic sync();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!pwm_s && k < 2*PER);
        chk("sync_strobe", int'(pwm_s), 1);
    endtask

    // Called right after a strobe: samples exactly one period, cnt 0..PER-1.
    task automatic measure();
        int strobe_at;
        strobe_at = -1;
        chk("dth_idx", int'(dth_idx), tb_idx);
        for (int c = 0; c < CHN; c++) begin
            hi[c] = 0; first_hi[c] = -1; last_hi[c] = -1;
        end
        for (int k = 0; k < PER; k++) begin
            tick();
            for (int c = 0; c < CHN; c++) begin
                if (pwm_o[c]) begin
                    hi[c]++;
                    if (first_hi[c] < 0) first_hi[c] = k;
                    last_hi[c] = k;
                end
            end
            if (pwm_s && strobe_at < 0) strobe_at = k;
        end
        chk("strobe_pos", strobe_at, PER - 1);
    endtask

    task automatic expect_hi(input int e0, input int e1, input int e2, input int e3);
        chk("hi_ch0", hi[0], e0);
        chk("hi_ch1", hi[1], e1);
        chk("hi_ch2", hi[2], e2);
        chk("hi_ch3", hi[3], e3);
    endtask

    logic [DTH-1:0] pats[3];
    logic [DTH-1:0] pat;
    logic [CHN-1:0] seen;
    int             n;
    int             e0;
    int             e2;
    logic [CHN*CCW-1:0] cfg_b;
    logic [CHN*CCW-1:0] cfg_c;

    initial begin
        pats[0] = 16'h0001; pats[1] = 16'h5555; pats[2] = 16'hFFFF;
        rstn = 1'b0; en = 1'b1; cfg = '0; cfg_we = 1'b0;
`ifdef RP_PWM_CENTER_EN
        align = '0;
`endif
        #1;
        chk("rst_pwm_o", int'(pwm_o), 0);
        chk("rst_pwm_s", int'(pwm_s), 0);
        chk("rst_cfg_pend", int'(cfg_pend), 0);
        chk("rst_dth_idx", int'(dth_idx), 0);
        tick(); tick();
        rstn = 1'b1;

        // Idle after reset: strobe 156 cycles after release, outputs low.
        n = 0; seen = '0;
        do begin
            tick();
            n++;
            seen |= pwm_o;
        end while (!pwm_s && n < 2*PER);
        chk("first_strobe", n, PER);
        chk("first_idx", int'(dth_idx), 1);
        chk("idle_pwm_o", int'(seen), 0);
        for (int i = 0; i < DTH; i++) begin
            measure();
            expect_hi(0, 0, 0, 0);
        end

        // Integer duty, including zero, exactly PER and saturated.
        write_cfg({w(255, 16'h0), w(156, 16'h0), w(0, 16'h0), w(33, 16'h0)});
        chk("pend_set", int'(cfg_pend), 1);
        sync();
        chk("pend_clr", int'(cfg_pend), 0);
        measure();
        expect_hi(33, 0, 156, 156);
        chk("ch0_first", first_hi[0], 0);
        chk("ch0_last", last_hi[0], 32);

        // Dither patterns on ch0; ch1 {155,FFFF} and ch3 {255,FFFF} saturate; ch2 {0,0001}.
        for (int p = 0; p < 3; p++) begin
            pat = pats[p];
            write_cfg({w(255, 16'hFFFF), w(0, 16'h0001), w(155, 16'hFFFF), w(33, pat)});
            sync();
            for (int i = 0; i < DTH; i++) begin
                e0 = 33 + int'(pat[tb_idx]);
                e2 = (tb_idx == 0) ? 1 : 0;
                measure();
                expect_hi(e0, 156, e2, 156);
            end
        end

        // Write mid-period at cnt=50: old duty (34) finishes the period.
        cfg_b = {w(200, 16'h0), w(0, 16'h0), w(156, 16'h0), w(100, 16'h0)};
        n = 0;
        for (int k = 0; k < PER; k++) begin
            tick();
            if (pwm_o[0]) n++;
            if (k == 49) begin
                cfg = cfg_b; cfg_we = 1'b1;
            end
            if (k == 50) begin
                cfg_we = 1'b0;
                chk("mid_pend", int'(cfg_pend), 1);
            end
            if (k == 154) chk("pre_bnd_pend", int'(cfg_pend), 1);
        end
        chk("mid_strobe", int'(pwm_s), 1);
        chk("mid_old_hi", n, 34);
        chk("mid_pend_clr", int'(cfg_pend), 0);
        measure();
        expect_hi(100, 156, 0, 156);
        chk("new_first", first_hi[0], 0);

        // Write on the boundary cycle takes effect one period later.
        cfg_c = {w(200, 16'h0), w(0, 16'h0), w(156, 16'h0), w(10, 16'h0)};
        for (int k = 0; k < PER - 1; k++) tick();
        cfg = cfg_c; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("bnd_strobe", int'(pwm_s), 1);
        chk("bnd_pend", int'(cfg_pend), 1);
        measure();
        expect_hi(100, 156, 0, 156);
        chk("bnd_pend_clr", int'(cfg_pend), 0);
        measure();
        expect_hi(10, 156, 0, 156);

        // en dropped at cnt=80, write while disabled, restart at cnt 0 with index 0.
        for (int k = 0; k < 80; k++) tick();
        chk("pre_dis_pwm", int'(pwm_o), 4'b1010);
        en = 1'b0;
        tick();
        chk("dis_pwm_o", int'(pwm_o), 0);
        chk("dis_pwm_s", int'(pwm_s), 0);
        chk("dis_idx", int'(dth_idx), 0);
        write_cfg({w(200, 16'h0), w(0, 16'h0), w(156, 16'h0), w(20, 16'h0)});
        chk("dis_pend", int'(cfg_pend), 1);
        tick(); tick();
        en = 1'b1;
        measure();
        expect_hi(10, 156, 0, 156);
        chk("ren_pend_clr", int'(cfg_pend), 0);
        measure();
        expect_hi(20, 156, 0, 156);

        // Async reset at cnt=80 clears outputs without a clock edge.
        write_cfg(cfg_c);
        chk("rst_pre_pend", int'(cfg_pend), 1);
        for (int k = 0; k < 79; k++) tick();
        chk("pre_rst_pwm", int'(pwm_o), 4'b1010);
        rstn = 1'b0;
        #1;
        chk("async_pwm_o", int'(pwm_o), 0);
        chk("async_pwm_s", int'(pwm_s), 0);
        chk("async_pend", int'(cfg_pend), 0);
        chk("async_idx", int'(dth_idx), 0);
        tick(); tick();
        rstn = 1'b1;
        measure();
        expect_hi(0, 0, 0, 0);

`ifdef RP_PWM_CENTER_EN
        align = 4'b0001;
        write_cfg({w(0, 16'h0), w(0, 16'h0), w(0, 16'h0), w(100, 16'h0)});
        sync();
        measure();
        chk("ctr100_hi", hi[0], 100);
        chk("ctr100_first", first_hi[0], 28);
        chk("ctr100_last", last_hi[0], 127);
        write_cfg({w(0, 16'h0), w(0, 16'h0), w(0, 16'h0), w(101, 16'h0)});
        sync();
        measure();
        chk("ctr101_first", first_hi[0], 27);
        chk("ctr101_last", last_hi[0], 127);
        align = 4'b0000;
        write_cfg({w(0, 16'h0), w(0, 16'h0), w(0, 16'h0), w(100, 16'h0)});
        sync();
        measure();
        chk("edge_first", first_hi[0], 0);
        chk("edge_last", last_hi[0], 99);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
